// File: rtl/adam_obi_fork_join_pkg.sv
// rtl/adam_obi_fork_join_pkg.sv - shared widths and channel indices for the OBI fork/join
package adam_obi_fork_join_pkg;

    localparam int CH_DATA = 0;
    localparam int CH_TAGS = 1;

    // Counter able to hold 0..max_count inclusive.
    function automatic int cnt_width(input int max_count);
        return $clog2(max_count) + 1;
    endfunction

    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/adam_sync_fifo.sv
// rtl/adam_sync_fifo.sv - per-channel response queue with optional fall-through bypass
module adam_sync_fifo
    import adam_obi_fork_join_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int DEPTH        = 2,
    parameter int FALL_THROUGH = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  pop,
    output logic                  valid,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  full
);
    localparam int PW = ptr_width(DEPTH);
    localparam int CW = cnt_width(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         rptr;
    logic [PW-1:0]         wptr;
    logic [CW-1:0]         count;
    logic                  empty;
    logic                  bypass;
    logic                  wr;
    logic                  rd;

    assign empty  = (count == '0);
    assign full   = (count == CW'(DEPTH));
    // An entry arriving into an empty queue and consumed the same cycle never gets stored.
    assign bypass = (FALL_THROUGH != 0) && empty && push && pop;
    assign wr     = push && (!full || pop) && !bypass;
    assign rd     = pop && !empty;
    assign valid  = !empty || ((FALL_THROUGH != 0) && push);
    assign rdata  = ((FALL_THROUGH != 0) && empty) ? wdata : mem[rptr];

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] ptr);
        return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else begin
            if (wr) begin
                mem[wptr] <= wdata;
                wptr      <= next_ptr(wptr);
            end
            if (rd) begin
                rptr <= next_ptr(rptr);
            end
            count <= count + CW'(wr) - CW'(rd);
        end
    end

endmodule

// File: rtl/adam_obi_fork_join.sv
// rtl/adam_obi_fork_join.sv - forks one OBI request to N channels and joins their responses in order
module adam_obi_fork_join
    import adam_obi_fork_join_pkg::*;
#(
    parameter int NO_CHANNELS     = 2,
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 2,
    parameter int FALL_THROUGH    = 0
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              slv_req,
    output logic                              slv_gnt,
    input  logic [ADDR_WIDTH-1:0]             slv_addr,
    input  logic [NO_CHANNELS-1:0]            slv_we,
    input  logic [DATA_WIDTH/8-1:0]           slv_be,
    input  logic [NO_CHANNELS*DATA_WIDTH-1:0] slv_wdata,
    output logic                              slv_rvalid,
    input  logic                              slv_rready,
    output logic [NO_CHANNELS*DATA_WIDTH-1:0] slv_rdata,
    output logic [NO_CHANNELS-1:0]            mst_req,
    input  logic [NO_CHANNELS-1:0]            mst_gnt,
    output logic [NO_CHANNELS*ADDR_WIDTH-1:0] mst_addr,
    output logic [NO_CHANNELS-1:0]            mst_we,
    output logic [NO_CHANNELS*DATA_WIDTH/8-1:0] mst_be,
    output logic [NO_CHANNELS*DATA_WIDTH-1:0] mst_wdata,
    input  logic [NO_CHANNELS-1:0]            mst_rvalid,
    output logic [NO_CHANNELS-1:0]            mst_rready,
    input  logic [NO_CHANNELS*DATA_WIDTH-1:0] mst_rdata,
    output logic                              err
);
    localparam int CW = cnt_width(MAX_OUTSTANDING);
    localparam int BW = DATA_WIDTH / 8;

    logic [CW-1:0]          outstanding;
    logic [NO_CHANNELS-1:0] gnt_done;
    logic [NO_CHANNELS-1:0] fifo_valid;
    logic [NO_CHANNELS-1:0] fifo_full;
    logic [NO_CHANNELS-1:0] push;
    logic [NO_CHANNELS-1:0] spurious;
    logic [NO_CHANNELS-1:0] overflow;
    logic                   credit_ok;
    logic                   pop;

    assign pop        = slv_rvalid & slv_rready;
    // A pop frees one queue slot in the same cycle, so a request may take its credit immediately.
    assign credit_ok  = (outstanding < CW'(MAX_OUTSTANDING)) | pop;
    assign mst_req    = {NO_CHANNELS{slv_req & credit_ok}} & ~gnt_done;
    assign slv_gnt    = slv_req & credit_ok & (&(gnt_done | mst_gnt));
    assign slv_rvalid = &fifo_valid;
    assign mst_rready = '1;
    assign mst_we     = slv_we;
    assign mst_wdata  = slv_wdata;

    for (genvar i = 0; i < NO_CHANNELS; i++) begin : g_ch
        logic [CW-1:0] pending;

        assign mst_addr[i*ADDR_WIDTH +: ADDR_WIDTH] = slv_addr;
        assign mst_be[i*BW +: BW]                   = slv_be;
        assign push[i]     = mst_rvalid[i] & (pending != '0);
        assign spurious[i] = mst_rvalid[i] & (pending == '0);
        assign overflow[i] = push[i] & fifo_full[i] & ~pop;

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                pending <= '0;
            end else begin
                pending <= pending + CW'(mst_req[i] & mst_gnt[i]) - CW'(push[i]);
            end
        end

        adam_sync_fifo #(
            .DATA_WIDTH  (DATA_WIDTH),
            .DEPTH       (MAX_OUTSTANDING),
            .FALL_THROUGH(FALL_THROUGH)
        ) u_fifo (
            .clk  (clk),
            .rst_n(rst_n),
            .push (push[i]),
            .wdata(mst_rdata[i*DATA_WIDTH +: DATA_WIDTH]),
            .pop  (pop),
            .valid(fifo_valid[i]),
            .rdata(slv_rdata[i*DATA_WIDTH +: DATA_WIDTH]),
            .full (fifo_full[i])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            outstanding <= '0;
            gnt_done    <= '0;
            err         <= 1'b0;
        end else begin
            outstanding <= outstanding + CW'(slv_gnt) - CW'(pop);
            if (slv_gnt) begin
                gnt_done <= '0;
            end else begin
                gnt_done <= gnt_done | (mst_req & mst_gnt);
            end
            if (|(spurious | overflow)) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_adam_obi_fork_join.sv
// tb/tb_adam_obi_fork_join.sv - scoreboard bench for adam_obi_fork_join (registered and fall-through instances)
module tb_adam_obi_fork_join;
    import adam_obi_fork_join_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic [31:0] addr = '0;
    logic [1:0]  we = '0;
    logic [3:0]  be = '0;
    logic [63:0] wdata = '0;
    logic        rready = 1'b1;
    logic [1:0]  mgnt = '0;
    logic [1:0]  mrvalid = '0;
    logic [63:0] mrdata = '0;

    logic        gnt0, rvalid0, err0, gnt1, rvalid1, err1;
    logic [63:0] rdata0, rdata1, mwdata0, mwdata1;
    logic [1:0]  mreq0, mwe0, mrready0, mreq1, mwe1, mrready1;
    logic [63:0] maddr0, maddr1;
    logic [7:0]  mbe0, mbe1;

    int errors = 0;
    int checks = 0;
    logic [63:0] exp_q[$];

    always #5 clk = ~clk;

    adam_obi_fork_join #(.FALL_THROUGH(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .slv_req(req), .slv_gnt(gnt0), .slv_addr(addr),
        .slv_we(we), .slv_be(be), .slv_wdata(wdata), .slv_rvalid(rvalid0),
        .slv_rready(rready), .slv_rdata(rdata0), .mst_req(mreq0), .mst_gnt(mgnt),
        .mst_addr(maddr0), .mst_we(mwe0), .mst_be(mbe0), .mst_wdata(mwdata0),
        .mst_rvalid(mrvalid), .mst_rready(mrready0), .mst_rdata(mrdata), .err(err0)
    );

    adam_obi_fork_join #(.FALL_THROUGH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .slv_req(req), .slv_gnt(gnt1), .slv_addr(addr),
        .slv_we(we), .slv_be(be), .slv_wdata(wdata), .slv_rvalid(rvalid1),
        .slv_rready(rready), .slv_rdata(rdata1), .mst_req(mreq1), .mst_gnt(mgnt),
        .mst_addr(maddr1), .mst_we(mwe1), .mst_be(mbe1), .mst_wdata(mwdata1),
        .mst_rvalid(mrvalid), .mst_rready(mrready1), .mst_rdata(mrdata), .err(err1)
    );

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic samp();
        @(negedge clk);
    endtask

    // Monitor: every accepted joined response of the registered instance is popped against the scoreboard.
    always @(negedge clk) begin
        if (rst_n && rvalid0 && rready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_rsp", rdata0, 64'hx);
            end else begin
                chk("rsp_rdata", rdata0, exp_q.pop_front());
            end
        end
    end

    initial begin
        logic [63:0] d1, d2, d3, dft;
        d1  = 64'hD1D1D1D1_11110000;
        d2  = 64'hD2D2D2D2_22220000;
        d3  = 64'hD3D3D3D3_33330000;
        dft = 64'h0F0F0F0F_F0F0F0F0;

        tick(); tick();
        rst_n = 1'b1;
        samp();
        chk("reset_gnt", gnt0, 0);
        chk("reset_rvalid", rvalid0, 0);
        chk("reset_mst_req", mreq0, 0);
        chk("reset_err", err0, 0);
        chk("mst_rready", {mrready1, mrready0}, 4'hF);
        tick();

        // Fall-through vs registered response latency.
        req = 1'b1; mgnt = 2'b11; addr = 32'h40;
        samp();
        chk("zero_lat_gnt", {gnt1, gnt0}, 2'b11);
        tick();
        req = 1'b0; mgnt = 2'b00;
        tick();
        mrvalid = 2'b11; mrdata = dft; exp_q.push_back(dft);
        samp();
        chk("ft1_rvalid_same", rvalid1, 1);
        chk("ft1_rdata", rdata1, dft);
        chk("ft0_rvalid_same", rvalid0, 0);
        tick();
        mrvalid = 2'b00;
        samp();
        chk("ft0_rvalid_next", rvalid0, 1);
        chk("ft1_rvalid_next", rvalid1, 0);
        tick();

        // Skewed grants: ch0 at cycle 0, ch1 at cycle 3.
        req = 1'b1; addr = 32'h100; we = 2'b00; mgnt = 2'b01;
        samp();
        chk("skew_c0_mst_req", mreq0, 2'b11);
        chk("skew_c0_gnt", gnt0, 0);
        chk("skew_addr", maddr0, {32'h100, 32'h100});
        tick();
        mgnt = 2'b00;
        for (int c = 1; c <= 2; c++) begin
            samp();
            chk("skew_mid_mst_req", mreq0, 2'b10);
            chk("skew_mid_gnt", gnt0, 0);
            tick();
        end
        mgnt = 2'b10;
        samp();
        chk("skew_c3_mst_req", mreq0, 2'b10);
        chk("skew_c3_gnt", gnt0, 1);
        tick();
        req = 1'b0; mgnt = 2'b00;
        chk("skew_outstanding", dut0.outstanding, 1);
        tick();
        mrvalid = 2'b01; mrdata = {32'h0, 32'hAAAA5555};
        tick();
        mrvalid = 2'b00;
        for (int c = 6; c <= 9; c++) tick();
        mrvalid = 2'b10; mrdata = {32'h0000000F, 32'h0};
        exp_q.push_back({32'h0000000F, 32'hAAAA5555});
        samp();
        chk("skew_c10_rvalid", rvalid0, 0);
        tick();
        mrvalid = 2'b00;
        samp();
        chk("skew_c11_rvalid", rvalid0, 1);
        tick();
        samp();
        chk("skew_c12_rvalid", rvalid0, 0);
        chk("skew_outstanding_end", dut0.outstanding, 0);
        tick();

        // Credit limit and rready backpressure.
        rready = 1'b0; req = 1'b1; mgnt = 2'b11; addr = 32'h200; we = 2'b01; be = 4'hF;
        wdata = {32'h22222222, 32'h11111111};
        samp();
        chk("cred_gnt1", gnt0, 1);
        chk("fork_wdata", mwdata0, {32'h22222222, 32'h11111111});
        chk("fork_be", mbe0, 8'hFF);
        chk("fork_we", mwe0, 2'b01);
        chk("fork_tags_addr", maddr0[CH_TAGS*32 +: 32], 32'h200);
        tick();
        samp();
        chk("cred_gnt2", gnt0, 1);
        tick();
        samp();
        chk("cred_hold_gnt", gnt0, 0);
        chk("cred_hold_mst_req", mreq0, 2'b00);
        tick();
        mrvalid = 2'b11; mrdata = d1; exp_q.push_back(d1);
        samp();
        chk("cred_d_gnt", gnt0, 0);
        tick();
        mrvalid = 2'b11; mrdata = d2; exp_q.push_back(d2);
        for (int c = 0; c < 4; c++) begin
            samp();
            chk("bp_rvalid", rvalid0, 1);
            chk("bp_rdata", rdata0, d1);
            chk("bp_gnt", gnt0, 0);
            tick();
            mrvalid = 2'b00;
        end
        rready = 1'b1;
        samp();
        chk("pop_cycle_gnt", gnt0, 1);
        chk("pop_data_lane", rdata0[CH_DATA*32 +: 32], 32'h11110000);
        tick();
        req = 1'b0;
        chk("pop_grant_outstanding", dut0.outstanding, 2);
        samp();
        chk("second_pop_rvalid", rvalid0, 1);
        tick();
        samp();
        chk("drained_rvalid", rvalid0, 0);
        chk("drained_outstanding", dut0.outstanding, 1);
        tick();
        mrvalid = 2'b11; mrdata = d3; exp_q.push_back(d3);
        tick();
        mrvalid = 2'b00;
        tick(); tick();

        // Spurious response, then reset with a half-granted request.
        mrvalid = 2'b10; mrdata = 64'h12345678_00000000;
        samp();
        chk("err_before", err0, 0);
        tick();
        mrvalid = 2'b00;
        samp();
        chk("err_set", err0, 1);
        chk("err_no_rvalid", rvalid0, 0);
        tick();
        req = 1'b1; we = 2'b00; mgnt = 2'b01;
        tick();
        mgnt = 2'b00;
        samp();
        chk("half_mst_req", mreq0, 2'b10);
        chk("half_gnt_done", dut0.gnt_done, 2'b01);
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1; req = 1'b0;
        samp();
        chk("rst_err", err0, 0);
        chk("rst_outstanding", dut0.outstanding, 0);
        chk("rst_gnt_done", dut0.gnt_done, 0);
        chk("rst_rvalid", rvalid0, 0);
        tick();
        req = 1'b1;
        samp();
        chk("rst_rerequest", mreq0, 2'b11);
        tick();
        req = 1'b0;

        for (int c = 0; c < 20 && exp_q.size() != 0; c++) tick();
        chk("scoreboard_drained", 64'(exp_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
